// File: rtl/mux_pkg.sv
// Shared defaults and mode encodings for the registered N-to-1 channel multiplexer.
package mux_pkg;

    localparam int GJERESIA_DEF = 16;
    localparam int KANALE_DEF   = 4;

    localparam logic MODI_FIKS = 1'b0;
    localparam logic MODI_RR   = 1'b1;

endpackage

// File: rtl/arbitri_rr.sv
// Round-robin arbiter: grants the first requester above i_ptr, wrapping back to channel 0.
module arbitri_rr #(
    parameter int KANALE = 4,
    parameter int SW     = $clog2(KANALE)
) (
    input  logic [KANALE-1:0] i_kerkesa,
    input  logic [SW-1:0]     i_ptr,
    output logic [KANALE-1:0] o_grant,
    output logic [SW-1:0]     o_indeksi
);

    logic          w_hi;
    logic          w_lo;
    logic [SW-1:0] w_hi_idx;
    logic [SW-1:0] w_lo_idx;

    // Two passes: requesters strictly above ptr win first, then the wrap-around range 0..ptr.
    always_comb begin
        w_hi     = 1'b0;
        w_lo     = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = KANALE - 1; i >= 0; i--) begin
            if (i_kerkesa[i] && (i > int'(i_ptr))) begin
                w_hi     = 1'b1;
                w_hi_idx = SW'(i);
            end
            if (i_kerkesa[i] && (i <= int'(i_ptr))) begin
                w_lo     = 1'b1;
                w_lo_idx = SW'(i);
            end
        end
    end

    always_comb begin
        o_indeksi = w_hi ? w_hi_idx : w_lo_idx;
        o_grant   = '0;
        for (int i = 0; i < KANALE; i++) begin
            o_grant[i] = (w_hi || w_lo) && (o_indeksi == SW'(i));
        end
    end

endmodule

// File: rtl/mux_n_ne1_reg.sv
// Registered N-to-1 channel multiplexer with fixed-select and round-robin modes.
module mux_n_ne1_reg
    import mux_pkg::*;
#(
    parameter int GJERESIA = GJERESIA_DEF,
    parameter int KANALE   = KANALE_DEF,
    parameter int SW       = $clog2(KANALE)
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic [KANALE*GJERESIA-1:0] Hyrja,
    input  logic [KANALE-1:0]          HyrjaValid,
    output logic [KANALE-1:0]          HyrjaReady,
    input  logic [SW-1:0]              S,
    input  logic                       Modi,
    output logic [GJERESIA-1:0]        Dalja,
    output logic                       DaljaValid,
    input  logic                       DaljaReady,
    output logic [SW-1:0]              Kanali
);

    // Handshake: a word moves on any port in a cycle where its valid and ready are both 1;
    // valid never waits on ready, and HyrjaReady never looks at the Hyrja data.

    logic                r_valid;
    logic [GJERESIA-1:0] r_data;
    logic [SW-1:0]       r_kanali;
    logic [SW-1:0]       r_ptr;

    logic                w_slot;
    logic [KANALE-1:0]   w_rr_grant;
    logic [SW-1:0]       w_rr_idx;
    logic [KANALE-1:0]   w_fix_grant;
    logic [KANALE-1:0]   w_grant;
    logic [SW-1:0]       w_idx;
    logic                w_accept;
    logic [GJERESIA-1:0] w_data;

    arbitri_rr #(
        .KANALE (KANALE),
        .SW     (SW)
    ) u_arbitri (
        .i_kerkesa (HyrjaValid),
        .i_ptr     (r_ptr),
        .o_grant   (w_rr_grant),
        .o_indeksi (w_rr_idx)
    );

    assign w_slot = !r_valid || DaljaReady;

    // Out-of-range S matches no bit, so the channel is simply never offered.
    always_comb begin
        w_fix_grant = '0;
        for (int i = 0; i < KANALE; i++) begin
            w_fix_grant[i] = (int'(S) == i);
        end
    end

    assign w_grant    = (Modi == MODI_RR) ? w_rr_grant : w_fix_grant;
    assign w_idx      = (Modi == MODI_RR) ? w_rr_idx : S;
    assign HyrjaReady = (Reset_n && w_slot) ? w_grant : '0;
    assign w_accept   = |(HyrjaReady & HyrjaValid);

    always_comb begin
        w_data = '0;
        for (int i = 0; i < KANALE; i++) begin
            if (w_grant[i]) begin
                w_data = Hyrja[i*GJERESIA +: GJERESIA];
            end
        end
    end

    // ptr resets to the last channel so the first round-robin search starts at channel 0.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_kanali <= '0;
            r_ptr    <= SW'(KANALE - 1);
        end else begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_data   <= w_data;
                r_kanali <= w_idx;
                if (Modi == MODI_RR) begin
                    r_ptr <= w_rr_idx;
                end
            end else if (DaljaReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Dalja      = r_data;
    assign DaljaValid = r_valid;
    assign Kanali     = r_kanali;

endmodule

// File: tb/tb_mux_n_ne1_reg.sv
// Directed bench for mux_n_ne1_reg: scoreboard on the output port plus direct handshake checks.
module tb_mux_n_ne1_reg;
    import mux_pkg::*;

    localparam int G  = 16;
    localparam int K  = 4;
    localparam int SW = 2;
    localparam int EW = SW + G;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4-channel DUT
    logic [K*G-1:0] hyrja;
    logic [K-1:0]   hv, hr;
    logic [SW-1:0]  s;
    logic           modi;
    logic [G-1:0]   dalja;
    logic           dv, dr;
    logic [SW-1:0]  kanali;

    // 3-channel DUT for the out-of-range select case
    logic [3*G-1:0] hyrja3;
    logic [2:0]     hv3, hr3;
    logic [1:0]     s3;
    logic           modi3;
    logic [G-1:0]   dalja3;
    logic           dv3, dr3;
    logic [1:0]     kanali3;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    int n_cmp = 0;
    int n_err = 0;

    mux_n_ne1_reg #(.GJERESIA(G), .KANALE(K)) u_dut (
        .Clock(clk), .Reset_n(rst_n), .Hyrja(hyrja), .HyrjaValid(hv), .HyrjaReady(hr),
        .S(s), .Modi(modi), .Dalja(dalja), .DaljaValid(dv), .DaljaReady(dr), .Kanali(kanali)
    );

    mux_n_ne1_reg #(.GJERESIA(G), .KANALE(3)) u_dut3 (
        .Clock(clk), .Reset_n(rst_n), .Hyrja(hyrja3), .HyrjaValid(hv3), .HyrjaReady(hr3),
        .S(s3), .Modi(modi3), .Dalja(dalja3), .DaljaValid(dv3), .DaljaReady(dr3), .Kanali(kanali3)
    );

    function automatic logic [G-1:0] word(input int k);
        return G'(16'h0A00 + 16'h0011 * k);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k);
        exp_q.push_back({SW'(k), word(k)});
    endtask

    // Monitor: every output transfer is checked against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dv === 1'b1 && dr === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got kanali=%0d dalja=%h, required no word", kanali, dalja);
            end else begin
                e = exp_q.pop_front();
                if ({kanali, dalja} !== e) begin
                    n_err++;
                    $display("FAIL out_word: got kanali=%0d dalja=%h, required kanali=%0d dalja=%h",
                             kanali, dalja, e[EW-1:G], e[G-1:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < K; i++) hyrja[i*G +: G] = word(i);
        for (int i = 0; i < 3; i++) hyrja3[i*G +: G] = word(i);
        hv = '0; s = '0; modi = MODI_FIKS; dr = 1'b1;
        hv3 = '0; s3 = '0; modi3 = MODI_FIKS; dr3 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dv, 0);
        check("rst_dalja", dalja, 0);
        check("rst_kanali", kanali, 0);
        check("rst_ready", hr, 0);
        rst_n = 1'b1;
        #1;
        check("fix_idle_ready", hr, 4'b0001);

        // Fixed select, channel 2
        hyrja[2*G +: G] = 16'hA5A5;
        s = 2'd2; hv = 4'b0100;
        #1;
        check("fix_ready", hr, 4'b0100);
        exp_q.push_back({2'd2, 16'hA5A5});
        tick();
        hv = '0;
        check("fix_valid", dv, 1);
        check("fix_dalja", dalja, 16'hA5A5);
        check("fix_kanali", kanali, 2);
        tick();
        check("fix_drain", dv, 0);
        hyrja[2*G +: G] = word(2);

        // Round-robin, all channels valid, fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        modi = MODI_RR; hv = 4'b1111;
        #1;
        check("rr_first_ready", hr, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            push(k % 4);
            tick();
            check("rr_no_gap", dv, 1);
            check("rr_kanali", kanali, k % 4);
        end
        hv = '0;
        tick();

        // Backpressure: word from channel 1 held for 5 cycles
        hv = 4'b1111; dr = 1'b0;
        push(1);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_ready", hr, 0);
            check("bp_dalja", dalja, word(1));
            check("bp_kanali", kanali, 1);
            tick();
        end
        dr = 1'b1;
        #1;
        check("bp_release_ready", hr, 4'b0100);
        push(2);
        tick();
        check("bp_next_valid", dv, 1);
        check("bp_next_kanali", kanali, 2);
        push(3);
        tick();
        hv = '0;
        tick();

        // Sparse round-robin: reach ptr=1, then ch1/ch3 alternate
        hv = 4'b0010;
        #1;
        check("sp_setup_ready", hr, 4'b0010);
        push(1);
        tick();
        hv = 4'b1010;
        #1;
        check("sp_grant3_a", hr, 4'b1000);
        push(3);
        tick();
        check("sp_grant1", hr, 4'b0010);
        push(1);
        tick();
        check("sp_grant3_b", hr, 4'b1000);
        push(3);
        tick();
        hv = '0;
        #1;
        check("rr_none_ready", hr, 0);
        tick();
        hv = 4'b1010;
        #1;
        check("rr_ptr_hold", hr, 4'b0010);
        hv = '0;
        tick();

        // Reset mid-stream discards the held word and restores channel-0 priority
        hv = 4'b1111; dr = 1'b0;
        push(0);
        tick();
        check("mid_held", dv, 1);
        hv = 4'b1001;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", dv, 0);
        check("mid_rst_dalja", dalja, 0);
        check("mid_rst_kanali", kanali, 0);
        check("mid_rst_ready", hr, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1; dr = 1'b1;
        #1;
        check("rst_first_grant", hr, 4'b0001);
        push(0);
        tick();
        hv = '0;
        tick();

        // Select and mode changes: immediate on grant, no effect on a held word
        modi = MODI_FIKS; s = 2'd1; hv = 4'b1111;
        #1;
        check("sel_ready_1", hr, 4'b0010);
        s = 2'd3;
        #1;
        check("sel_change", hr, 4'b1000);
        push(3);
        tick();
        dr = 1'b0; s = 2'd0; modi = MODI_RR;
        #1;
        check("chg_dalja", dalja, word(3));
        check("chg_kanali", kanali, 3);
        check("chg_ready", hr, 0);
        tick();
        check("chg_hold_dalja", dalja, word(3));
        check("chg_hold_kanali", kanali, 3);
        hv = '0; dr = 1'b1;
        tick();

        // Illegal select on the 3-channel instance
        hv3 = 3'b111; s3 = 2'd3;
        #1;
        check("ill_ready", hr3, 0);
        tick();
        check("ill_no_xfer", dv3, 0);
        s3 = 2'd2;
        #1;
        check("legal3_ready", hr3, 3'b100);
        tick();
        hv3 = '0;
        check("legal3_valid", dv3, 1);
        check("legal3_kanali", kanali3, 2);
        check("legal3_dalja", dalja3, word(2));

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
